// File: rtl/alu_pkg.sv
// Function codes and types shared by the shared-ALU arbiter and its ALU.
package alu_pkg;
  typedef logic [3:0] alu_func_t;

  localparam alu_func_t ALU_ADD  = 4'h0;
  localparam alu_func_t ALU_SLL  = 4'h1;
  localparam alu_func_t ALU_SLT  = 4'h2;
  localparam alu_func_t ALU_SLTU = 4'h3;
  localparam alu_func_t ALU_XOR  = 4'h4;
  localparam alu_func_t ALU_SRL  = 4'h5;
  localparam alu_func_t ALU_OR   = 4'h6;
  localparam alu_func_t ALU_AND  = 4'h7;
  localparam alu_func_t ALU_SUB  = 4'h8;
  localparam alu_func_t ALU_SRA  = 4'hD;
endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Purely combinational 32-bit integer ALU; unknown func codes produce zero.
module alu_share_arbiter_alu
  import alu_pkg::*;
(
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  alu_func_t   f,
  output logic [31:0] s
);

  always_comb begin
    s = '0;
    case (f)
      ALU_ADD:  s = operand_a + operand_b;
      ALU_SUB:  s = operand_a - operand_b;
      ALU_SLL:  s = operand_a << operand_b[4:0];
      ALU_SLT:  s = {31'b0, $signed(operand_a) < $signed(operand_b)};
      ALU_SLTU: s = {31'b0, operand_a < operand_b};
      ALU_XOR:  s = operand_a ^ operand_b;
      ALU_SRL:  s = operand_a >> operand_b[4:0];
      ALU_SRA:  s = $signed(operand_a) >>> operand_b[4:0];
      ALU_OR:   s = operand_a | operand_b;
      ALU_AND:  s = operand_a & operand_b;
      default:  s = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between NREQ valid/ready requesters.
// Two-stage pipeline: ISSUE register -> ALU -> RSP register.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int TAG_W = 5
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [NREQ-1:0]         i_req_valid,
  output logic [NREQ-1:0]         o_req_ready,
  input  logic [NREQ*32-1:0]      i_req_op_a,
  input  logic [NREQ*32-1:0]      i_req_op_b,
  input  logic [NREQ*4-1:0]       i_req_func,
  input  logic [NREQ*TAG_W-1:0]   i_req_tag,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [31:0]             o_rsp_data,
  output logic [$clog2(NREQ)-1:0] o_rsp_id,
  output logic [TAG_W-1:0]        o_rsp_tag
);

  localparam int ID_W = $clog2(NREQ);
  typedef logic [ID_W-1:0] id_t;

  // First valid requester at or above the pointer, wrapping upward.
  function automatic id_t rr_pick(input logic [NREQ-1:0] req, input id_t ptr);
    id_t  pick;
    logic found;
    int   idx;
    pick  = ptr;
    found = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(ptr) + off) % NREQ;
      if (!found && req[idx]) begin
        pick  = id_t'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  id_t              rr_ptr;
  id_t              grant_idx;
  logic             grant_any;
  logic [NREQ-1:0]  grant;
  logic             advance;
  logic             issue_free;
  logic             accept;

  logic             iss_valid;
  logic [31:0]      iss_a;
  logic [31:0]      iss_b;
  alu_func_t        iss_func;
  id_t              iss_id;
  logic [TAG_W-1:0] iss_tag;
  logic [31:0]      alu_s;

  always_comb begin
    grant_idx = rr_pick(i_req_valid, rr_ptr);
    grant_any = |i_req_valid;
    grant     = '0;
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  assign advance     = !o_rsp_valid || i_rsp_ready;
  assign issue_free  = !iss_valid || advance;
  assign accept      = grant_any && issue_free && !i_reset;
  assign o_req_ready = (i_reset || !issue_free) ? '0 : grant;

  // A full stall (ISSUE full, RSP held) leaves the pointer and ISSUE untouched.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      iss_valid <= 1'b0;
      iss_a     <= '0;
      iss_b     <= '0;
      iss_func  <= ALU_ADD;
      iss_id    <= '0;
      iss_tag   <= '0;
      rr_ptr    <= '0;
    end else if (issue_free) begin
      iss_valid <= accept;
      if (accept) begin
        iss_a    <= i_req_op_a[32*int'(grant_idx) +: 32];
        iss_b    <= i_req_op_b[32*int'(grant_idx) +: 32];
        iss_func <= i_req_func[4*int'(grant_idx) +: 4];
        iss_tag  <= i_req_tag[TAG_W*int'(grant_idx) +: TAG_W];
        iss_id   <= grant_idx;
        rr_ptr   <= (grant_idx == id_t'(NREQ-1)) ? '0 : grant_idx + id_t'(1);
      end
    end
  end

  alu_share_arbiter_alu u_alu (
    .operand_a (iss_a),
    .operand_b (iss_b),
    .f         (iss_func),
    .s         (alu_s)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_rsp_id    <= '0;
      o_rsp_tag   <= '0;
    end else if (advance) begin
      o_rsp_valid <= iss_valid;
      if (iss_valid) begin
        o_rsp_data <= alu_s;
        o_rsp_id   <= iss_id;
        o_rsp_tag  <= iss_tag;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and randomized self-checking bench for alu_share_arbiter (NREQ=2).
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int NREQ  = 2;
  localparam int TAG_W = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [63:0] req_op_a = '0;
  logic [63:0] req_op_b = '0;
  logic [7:0]  req_func = '0;
  logic [9:0]  req_tag = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_id;
  logic [4:0]  rsp_tag;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        id;
    logic [4:0]  tag;
  } rsp_t;

  rsp_t exp_q[$];
  logic m_ptr = 1'b0;
  logic m_iss = 1'b0;
  logic m_rsp = 1'b0;
  logic [1:0] acc = '0;

  alu_func_t funcs [10] = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
                            ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND};

  always #5 clk = ~clk;

  alu_share_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_op_a  (req_op_a),
    .i_req_op_b  (req_op_b),
    .i_req_func  (req_func),
    .i_req_tag   (req_tag),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data),
    .o_rsp_id    (rsp_id),
    .o_rsp_tag   (rsp_tag)
  );

  function automatic logic [31:0] alu_model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return 32'd0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int k, input logic [3:0] f, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] tag, input logic v);
    req_func[4*k +: 4]  = f;
    req_op_a[32*k +: 32] = a;
    req_op_b[32*k +: 32] = b;
    req_tag[5*k +: 5]   = tag;
    req_valid[k]        = v;
  endtask

  task automatic doReset();
    reset     = 1'b1;
    req_valid = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Reference model of the handshake and pipeline occupancy, evaluated mid-cycle.
  always @(negedge clk) begin : monitor
    logic adv, free, g_any, g_idx;
    rsp_t e;
    if (reset) begin
      checkOutput("rst_ready", 32'(req_ready), 32'd0);
      m_ptr = 1'b0;
      m_iss = 1'b0;
      m_rsp = 1'b0;
      exp_q.delete();
    end else begin
      adv   = !m_rsp || rsp_ready;
      free  = !m_iss || adv;
      g_any = |req_valid;
      g_idx = req_valid[m_ptr] ? m_ptr : ~m_ptr;
      checkOutput("mon_ready", 32'(req_ready), (g_any && free) ? (g_idx ? 32'd2 : 32'd1) : 32'd0);
      checkOutput("mon_rsp_valid", 32'(rsp_valid), 32'(m_rsp));
      if (m_rsp && exp_q.size() > 0) begin
        e = exp_q[0];
        checkOutput("mon_data", rsp_data, e.data);
        checkOutput("mon_id", 32'(rsp_id), 32'(e.id));
        checkOutput("mon_tag", 32'(rsp_tag), 32'(e.tag));
      end
      if (m_rsp && rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (adv) m_rsp = m_iss;
      if (free) begin
        m_iss = g_any;
        if (g_any) begin
          e.data = alu_model(req_func[4*g_idx +: 4], req_op_a[32*g_idx +: 32], req_op_b[32*g_idx +: 32]);
          e.id   = g_idx;
          e.tag  = req_tag[5*g_idx +: 5];
          exp_q.push_back(e);
          m_ptr = ~g_idx;
        end
      end
    end
  end

  initial begin
    doReset();
    @(negedge clk);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_data", rsp_data, 32'd0);
    checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    tick();

    // Single ADD, two-edge latency, one-cycle response pulse
    rsp_ready = 1'b1;
    applyStimulus(0, ALU_ADD, 32'd5, 32'd3, 5'd7, 1'b1);
    @(negedge clk);
    checkOutput("t1_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = '0;
    @(negedge clk);
    checkOutput("t1_early_valid", 32'(rsp_valid), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("t1_valid", 32'(rsp_valid), 32'd1);
    checkOutput("t1_data", rsp_data, 32'd8);
    checkOutput("t1_id", 32'(rsp_id), 32'd0);
    checkOutput("t1_tag", 32'(rsp_tag), 32'd7);
    tick();
    @(negedge clk);
    checkOutput("t1_pulse_end", 32'(rsp_valid), 32'd0);
    tick();

    // Both requesters saturating: grants alternate starting at 0
    doReset();
    rsp_ready = 1'b1;
    applyStimulus(0, ALU_ADD, 32'd1, 32'd1, 5'd1, 1'b1);
    applyStimulus(1, ALU_XOR, 32'hF0, 32'hFF, 5'd2, 1'b1);
    for (int c = 0; c < 7; c++) begin
      if (c == 4) req_valid = '0;
      @(negedge clk);
      checkOutput($sformatf("t2_ready%0d", c), 32'(req_ready),
                  (c < 4) ? ((c % 2 == 0) ? 32'd1 : 32'd2) : 32'd0);
      if (c >= 2 && c < 6) begin
        checkOutput($sformatf("t2_valid%0d", c), 32'(rsp_valid), 32'd1);
        checkOutput($sformatf("t2_id%0d", c), 32'(rsp_id), 32'(c % 2));
        checkOutput($sformatf("t2_data%0d", c), rsp_data, (c % 2 == 0) ? 32'd2 : 32'h0F);
      end
      tick();
    end

    // SRA result held under back-pressure; ISSUE full blocks new accepts
    rsp_ready = 1'b0;
    applyStimulus(1, ALU_SRA, 32'h8000_0000, 32'd4, 5'd3, 1'b1);
    for (int c = 0; c < 6; c++) begin
      if (c == 5) rsp_ready = 1'b1;
      @(negedge clk);
      checkOutput($sformatf("t3_ready%0d", c), 32'(req_ready),
                  (c < 2 || c == 5) ? 32'd2 : 32'd0);
      if (c >= 2) begin
        checkOutput($sformatf("t3_valid%0d", c), 32'(rsp_valid), 32'd1);
        checkOutput($sformatf("t3_data%0d", c), rsp_data, 32'hF800_0000);
        checkOutput($sformatf("t3_tag%0d", c), 32'(rsp_tag), 32'd3);
      end
      tick();
    end
    req_valid = '0;
    repeat (2) tick();
    @(negedge clk);
    checkOutput("t3_drained", 32'(rsp_valid), 32'd0);
    tick();

    // Comparison and subtraction corner values
    rsp_ready = 1'b1;
    applyStimulus(0, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b1);
    @(negedge clk);
    checkOutput("t4_ready", 32'(req_ready), 32'd1);
    tick();
    applyStimulus(0, ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1);
    tick();
    applyStimulus(0, ALU_SUB, 32'd3, 32'd5, 5'd6, 1'b1);
    @(negedge clk);
    checkOutput("t4_slt", rsp_data, 32'd1);
    checkOutput("t4_slt_tag", 32'(rsp_tag), 32'd4);
    tick();
    req_valid = '0;
    @(negedge clk);
    checkOutput("t4_sltu", rsp_data, 32'd0);
    checkOutput("t4_sltu_tag", 32'(rsp_tag), 32'd5);
    tick();
    @(negedge clk);
    checkOutput("t4_sub", rsp_data, 32'hFFFF_FFFE);
    checkOutput("t4_sub_valid", 32'(rsp_valid), 32'd1);
    tick();

    // Reset with ISSUE and RSP both occupied
    rsp_ready = 1'b0;
    applyStimulus(0, ALU_ADD, 32'd100, 32'd23, 5'd9, 1'b1);
    tick();
    tick();
    reset = 1'b1;
    applyStimulus(1, ALU_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd10, 1'b1);
    tick();
    reset = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("t5_valid", 32'(rsp_valid), 32'd0);
    checkOutput("t5_data", rsp_data, 32'd0);
    checkOutput("t5_tag", 32'(rsp_tag), 32'd0);
    checkOutput("t5_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = '0;
    @(negedge clk);
    checkOutput("t5_no_stale", 32'(rsp_valid), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("t5_new_valid", 32'(rsp_valid), 32'd1);
    checkOutput("t5_new_data", rsp_data, 32'd123);
    checkOutput("t5_new_tag", 32'(rsp_tag), 32'd9);
    tick();

    // Random traffic; requesters hold their op until it is accepted
    acc = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        if (!req_valid[k] || acc[k])
          applyStimulus(k, funcs[$urandom_range(0, 9)], $urandom, $urandom,
                        5'($urandom), 1'($urandom));
      end
      rsp_ready = 1'($urandom);
      @(negedge clk);
      acc = req_valid & req_ready;
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    checkOutput("t6_queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("t6_idle", 32'(rsp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
